// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
interface mem_access_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: req/ack data-memory access, stalls upstream while a
// transaction is outstanding, feeds MEMtoWB with a result or a bubble.
//   state | meaning
//   IDLE  | evaluate EX/MEM slot; passthrough, misalign error, or launch access
//   WAIT  | request outstanding on dm port; stall; count towards timeout
//   RESP  | present the latched instruction and its load result
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [4:0]  RdAddr_in,
    input  logic        RegWrite_in,
    input  logic [1:0]  MemReWr_in,
    input  logic [2:0]  MemWHB_in,
    input  logic [31:0] Addr_in,
    input  logic [31:0] StoreData_in,
    mem_access_stage_if.master dm,
    output logic        stall_out,
    output logic [4:0]  RdAddr_out,
    output logic        RegWrite_out,
    output logic [1:0]  MemReWr_out,
    output logic [2:0]  MemWHB_out,
    output logic [31:0] RdVal_out,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    rd_q;
    logic          regwrite_q;
    logic [1:0]    rewr_q;
    logic [2:0]    whb_q;
    logic [1:0]    lane_q;
    logic [31:0]   rdval_q;

    logic          is_load, is_store, mem_op, size_ok, aligned, go, misalign, timeout;
    logic [3:0]    wstrb_in;
    logic [31:0]   wdata_in;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Unknown funct3 (and BU/HU on a store) is folded into the misalign path.
    always_comb begin
        is_load  = (MemReWr_in == 2'b10);
        is_store = (MemReWr_in == 2'b01);
        size_ok  = 1'b0;
        aligned  = 1'b1;
        case (MemWHB_in)
            3'b000: size_ok = 1'b1;
            3'b001: begin size_ok = 1'b1;    aligned = ~Addr_in[0]; end
            3'b010: begin size_ok = 1'b1;    aligned = (Addr_in[1:0] == 2'b00); end
            3'b100: size_ok = is_load;
            3'b101: begin size_ok = is_load; aligned = ~Addr_in[0]; end
            default: size_ok = 1'b0;
        endcase
        mem_op   = valid_in & (is_load | is_store);
        go       = mem_op & size_ok & aligned;
        misalign = mem_op & ~go;

        wstrb_in = 4'b0000;
        wdata_in = StoreData_in;
        if (is_store) begin
            case (MemWHB_in[1:0])
                2'b00: begin
                    wstrb_in = 4'b0001 << Addr_in[1:0];
                    wdata_in = {4{StoreData_in[7:0]}};
                end
                2'b01: begin
                    wstrb_in = 4'b0011 << Addr_in[1:0];
                    wdata_in = {2{StoreData_in[15:0]}};
                end
                default: wstrb_in = 4'b1111;
            endcase
        end
    end

    // Ack in the last allowed cycle wins over the timeout.
    assign timeout = (state == WAIT) & ~dm.dm_ack & (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            rewr_q      <= '0;
            whb_q       <= '0;
            lane_q      <= '0;
            rdval_q     <= '0;
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_wstrb <= '0;
            dm.dm_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        rd_q        <= RdAddr_in;
                        regwrite_q  <= RegWrite_in;
                        rewr_q      <= MemReWr_in;
                        whb_q       <= MemWHB_in;
                        lane_q      <= Addr_in[1:0];
                        rdval_q     <= '0;
                        cnt         <= '0;
                        dm.dm_req   <= 1'b1;
                        dm.dm_we    <= is_store;
                        dm.dm_addr  <= {Addr_in[31:2], 2'b00};
                        dm.dm_wstrb <= wstrb_in;
                        dm.dm_wdata <= wdata_in;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (dm.dm_ack) begin
                        rdval_q     <= (rewr_q == 2'b10) ? load_ext(dm.dm_rdata, lane_q, whb_q) : '0;
                        dm.dm_req   <= 1'b0;
                        dm.dm_we    <= 1'b0;
                        dm.dm_wstrb <= '0;
                        state       <= RESP;
                    end else if (timeout) begin
                        regwrite_q  <= 1'b0;
                        rdval_q     <= '0;
                        dm.dm_req   <= 1'b0;
                        dm.dm_we    <= 1'b0;
                        dm.dm_wstrb <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_out    = 1'b0;
        RdAddr_out   = '0;
        RegWrite_out = 1'b0;
        MemReWr_out  = '0;
        MemWHB_out   = '0;
        RdVal_out    = '0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    stall_out = go;
                    if (valid_in && !go) begin
                        RdAddr_out   = RdAddr_in;
                        RegWrite_out = RegWrite_in & ~misalign;
                        MemWHB_out   = MemWHB_in;
                        RdVal_out    = Addr_in;
                        misalign_err = misalign;
                    end
                end
                WAIT: begin
                    stall_out = 1'b1;
                    bus_err   = timeout;
                end
                RESP: begin
                    RdAddr_out   = rd_q;
                    RegWrite_out = regwrite_q;
                    MemReWr_out  = rewr_q;
                    MemWHB_out   = whb_q;
                    RdVal_out    = rdval_q;
                end
                default: stall_out = 1'b0;
            endcase
        end
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage data-memory access unit sitting between the EX/MEM pipeline register and `MEMtoWB`. It turns load/store control into a req/ack transaction on the data-memory port, builds byte strobes and store data, and sign- or zero-extends load data. It stalls the upstream pipeline while a transaction is outstanding. Its outputs feed `MEMtoWB` directly, as a result or as a bubble.

## Interface
Parameters:
- `TIMEOUT`, 16: max `WAIT` cycles before abort; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `valid_in`  in  1  EX/MEM slot holds a real instruction.
- `RdAddr_in`  in  5  destination register.
- `RegWrite_in`  in  1  instruction writes rd.
- `MemReWr_in`  in  2  `2'b10` load, `2'b01` store, `2'b00` none; `2'b11` is treated as none.
- `MemWHB_in`  in  3  funct3: `000` B, `001` H, `010` W, `100` BU, `101` HU.
- `Addr_in`  in  32  ALU result / effective address.
- `StoreData_in`  in  32  rs2 value.
- `dm_req`  out  1  memory request, registered.
- `dm_we`  out  1  write request.
- `dm_addr`  out  32  `{Addr[31:2],2'b00}`.
- `dm_wstrb`  out  4  byte strobes.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_ack`  in  1  request complete; `dm_rdata` valid in the same cycle.
- `dm_rdata`  in  32  read word.
- `stall_out`  out  1  hold all upstream stages.
- `RdAddr_out`, `RegWrite_out`, `MemReWr_out`, `MemWHB_out`, `RdVal_out`  out  5/1/2/3/32  to `MemtoWB`.
- `misalign_err`  out  1  one-cycle pulse.
- `bus_err`  out  1  one-cycle pulse on timeout.

## Operation
- States: `IDLE`, `WAIT`, `RESP`.
- `IDLE`, no memory op (`valid_in=0` or `MemReWr_in` none):
  - Outputs are combinational passthrough: `RdVal_out=Addr_in`, `RegWrite_out=RegWrite_in&valid_in`, `stall_out=0`.
  - If `valid_in=0`, output a bubble: all outputs zero.
- `IDLE`, aligned memory op:
  - Latch all inputs into internal registers and go to `WAIT`.
  - `stall_out=1` and a bubble are output this cycle.
- `WAIT`:
  - `dm_req=1`; `dm_we`, `dm_addr`, `dm_wstrb` and `dm_wdata` come from the latched values and stay stable until ack.
  - `stall_out=1`, bubble output, counter increments.
  - `dm_ack=1`: capture the extended load data (or zero for stores) into `RdVal` register and go to `RESP`.
  - Counter reaches `TIMEOUT` without ack: drop `dm_req`, pulse `bus_err`, go to `RESP` with `RegWrite` forced to 0.
- `RESP`:
  - Present the latched instruction with `RdVal_out`, `stall_out=0`, `dm_req=0`.
  - Next state is `IDLE`.
  - Upstream advances at this edge; the next instruction is first evaluated in the `IDLE` cycle that follows.
- Alignment rules:
  - H/HU/SH requires `Addr[0]=0`.
  - W/SW requires `Addr[1:0]=0`.
  - Bytes are always aligned.
- Misaligned op in `IDLE`:
  - No request, no stall.
  - Pulse `misalign_err` that cycle.
  - Output the instruction with `RegWrite_out=0` and `MemReWr_out=0`.
- Store strobes:
  - SB: `4'b0001<<a`.
  - SH: `4'b0011<<a`.
  - SW: `4'b1111`.
  - `a=Addr[1:0]`.
  - `dm_wdata`: SB `{4{d[7:0]}}`, SH `{2{d[15:0]}}`, SW `d`.
- Loads:
  - Select the byte lane `a` (or half lane `a[1]`).
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Unknown funct3 on a memory op is treated as a misaligned op (error pulse, no access).
- `dm_ack` outside `WAIT` is ignored.

## Timing
- Reset (`rst=0` at an edge), from any state including mid-`WAIT`:
  - State goes to `IDLE`; counter and all latched registers are cleared.
  - `dm_req`, `dm_we`, `dm_wstrb`, `stall_out`, `misalign_err`, `bus_err` are 0.
  - All `*_out` outputs are 0.
  - Any outstanding request is abandoned.
- Non-memory op: 0-cycle latency through the block, registered by `MEMtoWB`.
- Memory op with ack in the first `WAIT` cycle:
  - `stall_out` high 2 cycles (`IDLE`, `WAIT`), result at `RESP`.
  - Total latency 2 + N extra wait cycles.
- Timeout: `bus_err` rises in the `TIMEOUT`-th `WAIT` cycle; `RESP` follows.
- Ack and timeout in the same cycle: ack wins, no `bus_err`.

## Test plan
- ADD result `Addr_in=0x1234`, `RdAddr=5`, `RegWrite=1`, no memory op
  -> same cycle `RdVal_out=0x1234`, `RegWrite_out=1`, `stall_out=0`, `dm_req=0`.
- LB at `Addr=0x103`, `dm_rdata=0x80FF_0000` acked in the first `WAIT` cycle
  -> `dm_addr=0x100`, stall for 2 cycles, then `RESP` `RdVal_out=0xFFFF_FF80`; LBU at the same address gives `0x0000_0080`.
- SH at `Addr=0x22`, data `0xAAAA_BEEF`, ack after 3 wait cycles
  -> `dm_wstrb=4'b1100`, `dm_wdata=0xBEEF_BEEF`, `dm_we=1` held stable for 3 cycles, stall for 4 cycles, `RegWrite_out=0` at `RESP`.
- LW at `Addr=0x202`
  -> `misalign_err` pulse, `dm_req` stays 0, `stall_out=0`, `RegWrite_out=0`.
- LW with `dm_ack` never asserted, `TIMEOUT=16`
  -> `bus_err` pulse in `WAIT` cycle 16, `dm_req` drops, `RESP` with `RegWrite_out=0`, back to `IDLE`.
- `rst=0` asserted in the 2nd `WAIT` cycle of a load
  -> next edge: state `IDLE`, `dm_req=0`, `stall_out=0`, all outputs 0; a late `dm_ack` is ignored.
